// File: rtl/code_lock.sv
// rtl/code_lock.sv - four-digit code lock with wrong-code penalty, try counter and lockout
module code_lock #(
    parameter logic [15:0] CODE      = 16'h1234,
    parameter int          OPEN_CYC  = 10,
    parameter int          FAIL_CYC  = 5,
    parameter int          MAX_TRIES = 3
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       enter_pulse,
    input  logic [3:0] digit_in,
    output logic       unlocked,
    output logic       error,
    output logic       locked_out,
    output logic [2:0] digits_entered
);

    typedef enum logic [2:0] {
        IDLE, COLLECT, CHECK, OPEN, FAIL, LOCKOUT
    } state_t;

    localparam logic [7:0] OPEN_LD   = 8'(OPEN_CYC - 1);
    localparam logic [7:0] FAIL_LD   = 8'(FAIL_CYC - 1);
    localparam logic [3:0] TRIES_MAX = 4'(MAX_TRIES);

    state_t      state_q, state_d;
    logic [15:0] shift_q, shift_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [2:0]  tries_q, tries_d;
    logic [7:0]  dwell_q, dwell_d;
    logic        unlocked_q, unlocked_d;
    logic        error_q, error_d;
    logic        locked_q, locked_d;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= IDLE;
            shift_q    <= 16'h0000;
            cnt_q      <= 3'd0;
            tries_q    <= 3'd0;
            dwell_q    <= 8'd0;
            unlocked_q <= 1'b0;
            error_q    <= 1'b0;
            locked_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            cnt_q      <= cnt_d;
            tries_q    <= tries_d;
            dwell_q    <= dwell_d;
            unlocked_q <= unlocked_d;
            error_q    <= error_d;
            locked_q   <= locked_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        tries_d = tries_q;
        dwell_d = dwell_q;
        case (state_q)
            IDLE, COLLECT: begin
                if (enter_pulse) begin
                    shift_d = {shift_q[11:0], digit_in};
                    cnt_d   = cnt_q + 3'd1;
                    state_d = (cnt_q == 3'd3) ? CHECK : COLLECT;
                end
            end
            CHECK: begin
                shift_d = 16'h0000;
                cnt_d   = 3'd0;
                if (shift_q == CODE) begin
                    state_d = OPEN;
                    tries_d = 3'd0;
                    dwell_d = OPEN_LD;
                end else if (({1'b0, tries_q} + 4'd1) < TRIES_MAX) begin
                    state_d = FAIL;
                    tries_d = tries_q + 3'd1;
                    dwell_d = FAIL_LD;
                end else begin
                    state_d = LOCKOUT;
                end
            end
            OPEN, FAIL: begin
                if (dwell_q == 8'd0) begin
                    state_d = IDLE;
                end else begin
                    dwell_d = dwell_q - 8'd1;
                end
            end
            LOCKOUT: state_d = LOCKOUT;
            default: state_d = IDLE;
        endcase
    end

    // Indicators are a registered copy of the state decode, so they trail the state by one edge.
    always_comb begin
        unlocked_d = (state_q == OPEN);
        error_d    = (state_q == FAIL);
        locked_d   = (state_q == LOCKOUT);
    end

    assign unlocked       = unlocked_q;
    assign error          = error_q;
    assign locked_out     = locked_q;
    assign digits_entered = cnt_q;

endmodule

// File: tb/tb_code_lock.sv
// tb/tb_code_lock.sv - directed and randomized checks of code_lock against a window-based model
module tb_code_lock;

    localparam logic [15:0] CODE      = 16'h1234;
    localparam int          OPEN_CYC  = 10;
    localparam int          FAIL_CYC  = 5;
    localparam int          MAX_TRIES = 3;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       enter_pulse = 1'b0;
    logic [3:0] digit_in = 4'h0;
    logic       unlocked, error, locked_out;
    logic [2:0] digits_entered;

    int checks = 0;
    int errors = 0;

    code_lock #(.CODE(CODE), .OPEN_CYC(OPEN_CYC), .FAIL_CYC(FAIL_CYC), .MAX_TRIES(MAX_TRIES)) dut (
        .CLK(CLK), .RST(RST), .enter_pulse(enter_pulse), .digit_in(digit_in),
        .unlocked(unlocked), .error(error), .locked_out(locked_out),
        .digits_entered(digits_entered)
    );

    always #5 CLK = ~CLK;

    // Model: edge counter plus the edge windows in which each indicator must be high.
    int          n = 0;
    int          m_len = 0;
    logic [15:0] m_sh = 16'h0;
    int          m_tries = 0;
    int          e_edge = -10;
    int          accept_from = 0;
    int          unl_lo = 1, unl_hi = 0;
    int          err_lo = 1, err_hi = 0;
    bit          m_locked = 1'b0;
    int          lock_from = 0;

    task automatic model_reset();
        m_len = 0; m_sh = 16'h0; m_tries = 0; e_edge = -10; accept_from = 0;
        unl_lo = 1; unl_hi = 0; err_lo = 1; err_hi = 0; m_locked = 1'b0;
    endtask

    task automatic model_edge(input bit p, input logic [3:0] d);
        n++;
        if (m_len == 4 && n == e_edge + 1) m_len = 0;
        if (!m_locked && p && n >= accept_from) begin
            m_sh = {m_sh[11:0], d};
            m_len++;
            if (m_len == 4) begin
                e_edge = n;
                if (m_sh == CODE) begin
                    m_tries = 0;
                    unl_lo = n + 2; unl_hi = n + OPEN_CYC + 1;
                    accept_from = n + OPEN_CYC + 2;
                end else if (m_tries + 1 < MAX_TRIES) begin
                    m_tries++;
                    err_lo = n + 2; err_hi = n + FAIL_CYC + 1;
                    accept_from = n + FAIL_CYC + 2;
                end else begin
                    m_locked = 1'b1;
                    lock_from = n + 2;
                    accept_from = 32'h7fff_ffff;
                end
                m_sh = 16'h0;
            end
        end
    endtask

    task automatic check_outputs();
        logic       x_unl, x_err, x_lck;
        logic [2:0] x_dig;
        x_unl = (n >= unl_lo && n <= unl_hi);
        x_err = (n >= err_lo && n <= err_hi);
        x_lck = m_locked && (n >= lock_from);
        x_dig = 3'(m_len);
        checks++;
        assert (unlocked === x_unl) else begin
            errors++; $error("FAIL unlocked edge=%0d obs=%b exp=%b", n, unlocked, x_unl);
        end
        checks++;
        assert (error === x_err) else begin
            errors++; $error("FAIL error edge=%0d obs=%b exp=%b", n, error, x_err);
        end
        checks++;
        assert (locked_out === x_lck) else begin
            errors++; $error("FAIL locked_out edge=%0d obs=%b exp=%b", n, locked_out, x_lck);
        end
        checks++;
        assert (digits_entered === x_dig) else begin
            errors++; $error("FAIL digits_entered edge=%0d obs=%0d exp=%0d", n, digits_entered, x_dig);
        end
        checks++;
        assert (32'(unlocked) + 32'(error) + 32'(locked_out) <= 1) else begin
            errors++; $error("FAIL onehot edge=%0d obs=%b%b%b exp=at most one", n, unlocked, error, locked_out);
        end
    endtask

    task automatic step(input bit p, input logic [3:0] d);
        enter_pulse = p;
        digit_in    = d;
        @(posedge CLK);
        model_edge(p, d);
        #1;
        check_outputs();
    endtask

    task automatic idle(input int k);
        repeat (k) step(1'b0, 4'h0);
    endtask

    task automatic enter_code(input logic [15:0] c);
        logic [15:0] v;
        v = c;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, v[15:12]);
            step(1'b0, 4'h0);
            v = v << 4;
        end
    endtask

    // Reset is raised between edges; outputs must already be clear before the next edge.
    task automatic do_reset();
        enter_pulse = 1'b0;
        RST = 1'b1;
        #2;
        model_reset();
        check_outputs();
        @(posedge CLK);
        #1;
        RST = 1'b0;
    endtask

    initial begin
        logic [15:0] cv;
        logic [3:0]  rd;
        bit          rp;
        #2;
        model_reset();
        check_outputs();
        @(posedge CLK);
        #1;
        RST = 1'b0;

        // Correct code, then full unlock window and return to idle
        idle(2);
        enter_code(16'h1234);
        idle(14);

        // Wrong code then correct code
        enter_code(16'h1235);
        idle(8);
        enter_code(16'h1234);
        idle(14);

        // Three wrong codes lock out; a correct code is then ignored until reset
        enter_code(16'h1111);
        idle(8);
        enter_code(16'h4321);
        idle(8);
        enter_code(16'hABCD);
        idle(4);
        enter_code(16'h1234);
        idle(14);
        do_reset();

        // Held pulse counts every cycle: 7,7,7 held then one more 7
        step(1'b1, 4'h7);
        step(1'b1, 4'h7);
        step(1'b1, 4'h7);
        step(1'b0, 4'h0);
        step(1'b1, 4'h7);
        idle(8);

        // Pulses during CHECK and OPEN are ignored; reset mid-OPEN drops unlocked at once
        step(1'b1, 4'h1);
        step(1'b1, 4'h2);
        step(1'b1, 4'h3);
        step(1'b1, 4'h4);
        step(1'b1, 4'h9);
        step(1'b1, 4'h1);
        step(1'b1, 4'h2);
        idle(2);
        do_reset();
        idle(2);

        // Correct code clears the try counter
        enter_code(16'h0000);
        idle(8);
        enter_code(16'hFFFF);
        idle(8);
        enter_code(16'h1234);
        idle(14);
        enter_code(16'h1230);
        idle(8);
        enter_code(16'h2234);
        idle(8);
        enter_code(16'h1234);
        idle(14);

        // Randomized phase, biased toward the correct digit for the current position
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                rp = ($urandom_range(0, 2) != 0);
                cv = CODE >> (4 * (3 - (m_len % 4)));
                rd = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15)) : cv[3:0];
                step(rp, rd);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/code_lock.md
CODE_LOCK -- requirements
Module: code_lock

Interface
REQ-001 Parameter CODE, 16'h1234, four 4-bit digits of the access code, first-entered digit in bits [15:12].
REQ-002 Parameter OPEN_CYC, 10, cycles unlocked stays high after a correct code (range 1..255).
REQ-003 Parameter FAIL_CYC, 5, cycles error stays high after a wrong code (range 1..255).
REQ-004 Parameter MAX_TRIES, 3, consecutive wrong codes that force lockout (range 1..7).
REQ-005 CLK  input  1  system clock, all state updates on rising edge.
REQ-006 RST  input  1  reset, asynchronous, active-high.
REQ-007 enter_pulse  input  1  one-cycle press pulse from the upstream button shaper.
REQ-008 digit_in  input  4  digit value sampled on the edge where enter_pulse is high.
REQ-009 unlocked  output  1  high while code accepted.
REQ-010 error  output  1  high during wrong-code penalty.
REQ-011 locked_out  output  1  high in lockout, held until reset.
REQ-012 digits_entered  output  3  count of digits captured in the current attempt, 0..4.

Function
REQ-013 States SHALL be IDLE, COLLECT, CHECK, OPEN, FAIL, LOCKOUT; all outputs registered/Moore, no combinational input-to-output path.
REQ-014 IDLE/COLLECT: edge with enter_pulse=1 shifts digit_in into a 16-bit register (left shift, new digit in [3:0]) and increments digits_entered; first capture moves IDLE->COLLECT.
REQ-015 enter_pulse held high N cycles SHALL count as N presses; no edge detection here.
REQ-016 Edge capturing the 4th digit SHALL move to CHECK with digits_entered=4; enter_pulse ignored in CHECK.
REQ-017 CHECK lasts exactly one cycle; next edge compares full 16-bit register to CODE, raw 4-bit values (digits >9 accepted, compared as-is).
REQ-018 Match: ->OPEN, unlocked=1 for exactly OPEN_CYC cycles, try counter cleared, then ->IDLE.
REQ-019 Mismatch with tries+1 < MAX_TRIES: tries incremented, ->FAIL, error=1 for exactly FAIL_CYC cycles, then ->IDLE.
REQ-020 Mismatch with tries+1 = MAX_TRIES: ->LOCKOUT, locked_out=1, stays until RST.
REQ-021 On entry to OPEN, FAIL, LOCKOUT digits_entered and the shift register SHALL clear to 0.
REQ-022 enter_pulse in OPEN, FAIL, LOCKOUT SHALL be ignored (no capture, no count change).
REQ-023 Latency: 4th pulse sampled at edge E -> unlocked or error rises at edge E+2.
REQ-024 Dwell counter width 8 bits; loads OPEN_CYC-1 / FAIL_CYC-1 on entry, exits on reaching 0, no wrap.
REQ-025 At most one of unlocked, error, locked_out high in any cycle.

Reset
REQ-026 RST=1 SHALL immediately (asynchronously) force IDLE, tries=0, shift register=0, digits_entered=0, unlocked=error=locked_out=0, including mid-OPEN, mid-FAIL, mid-entry and LOCKOUT.
REQ-027 After RST falls, the first rising edge with enter_pulse=1 SHALL be captured normally.

Verification
REQ-028 Pulses with digits 1,2,3,4 -> digits_entered 1,2,3,4; unlocked=1 two edges after 4th pulse for 10 cycles, then 0, state IDLE.
REQ-029 Digits 1,2,3,5 -> error=1 for 5 cycles, unlocked stays 0, digits_entered returns 0; then 1,2,3,4 -> unlocked.
REQ-030 Three wrong codes in a row -> error after 1st and 2nd, locked_out=1 after 3rd; further correct code ignored until RST pulse clears locked_out.
REQ-031 enter_pulse high 3 consecutive cycles with digit 7, then one pulse digit 7 -> register 16'h7777, error=1.
REQ-032 Pulses during OPEN and during CHECK -> no change to digits_entered; RST asserted mid-OPEN -> unlocked drops before next clock edge.
REQ-033 Wrong, wrong, correct -> unlocked=1 and tries cleared; next two wrong codes give error only, no lockout.
